// File: rtl/qracc_psum_accumulator.sv
// Bit-plane shift-and-add accumulator for QR tile columns: thermometer ADC decode,
// per-column signed saturating partial sums, one-entry valid/ready result register.
module qracc_psum_accumulator #(
  parameter int numCols    = 8,
  parameter int numAdcBits = 4,
  parameter int numInBits  = 8,
  parameter int accBits    = 16,
  localparam int compCount = 2**numAdcBits - 1,
  localparam int cntBits   = $clog2(numInBits + 1)
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic [compCount*numCols-1:0] ADC_OUT,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_first,
  input  logic                         in_last,
  input  logic                         in_signed,
  output logic [numCols*accBits-1:0]   RESULT,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [cntBits-1:0]           plane_cnt,
  output logic                         err,
  output logic                         sat
);

  localparam int WW = accBits + 2;
  localparam logic signed [WW-1:0] ACC_MAX = (WW'(1) <<< (accBits - 1)) - WW'(1);
  localparam logic signed [WW-1:0] ACC_MIN = -(WW'(1) <<< (accBits - 1));
  localparam logic signed [WW-1:0] V_OFFSET = WW'(2**(numAdcBits - 1));

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                     state_q, state_d;
  logic signed [accBits-1:0]  acc_q [numCols];
  logic signed [accBits-1:0]  acc_d [numCols];
  logic signed [WW-1:0]       pop   [numCols];
  logic signed [WW-1:0]       v     [numCols];
  logic signed [WW-1:0]       sum   [numCols];
  logic [cntBits-1:0]         cnt_d;
  logic                       sat_run_q, sat_run_d;
  logic                       err_d;
  logic                       complete;
  logic                       accept;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Popcount rather than priority decode so comparator bubbles do not cause large errors.
  always_comb begin
    for (int j = 0; j < numCols; j++) begin
      pop[j] = '0;
      for (int k = 0; k < compCount; k++)
        pop[j] = pop[j] + WW'(ADC_OUT[j*compCount + k]);
      v[j] = pop[j] - V_OFFSET;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = plane_cnt;
    sat_run_d = sat_run_q;
    err_d     = 1'b0;
    complete  = 1'b0;
    for (int j = 0; j < numCols; j++) begin
      acc_d[j] = acc_q[j];
      sum[j]   = (WW'(acc_q[j]) <<< 1) + v[j];
    end

    if (accept) begin
      if (in_first) begin
        err_d     = (state_q == ACCUM);
        sat_run_d = 1'b0;
        cnt_d     = cntBits'(1);
        for (int j = 0; j < numCols; j++)
          acc_d[j] = accBits'(in_signed ? -v[j] : v[j]);
        if (in_last) begin
          complete = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
        end else begin
          state_d  = ACCUM;
        end
      end else if (state_q == IDLE) begin
        err_d = 1'b1;
      end else if (plane_cnt == cntBits'(numInBits)) begin
        // A plane beyond the maximum depth cannot be weighted correctly: abort.
        err_d   = 1'b1;
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = plane_cnt + cntBits'(1);
        for (int j = 0; j < numCols; j++) begin
          if (sum[j] > ACC_MAX) begin
            acc_d[j]  = ACC_MAX[accBits-1:0];
            sat_run_d = 1'b1;
          end else if (sum[j] < ACC_MIN) begin
            acc_d[j]  = ACC_MIN[accBits-1:0];
            sat_run_d = 1'b1;
          end else begin
            acc_d[j]  = sum[j][accBits-1:0];
          end
        end
        if (in_last) begin
          complete = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      plane_cnt <= '0;
      sat_run_q <= 1'b0;
      err       <= 1'b0;
      out_valid <= 1'b0;
      sat       <= 1'b0;
      RESULT    <= '0;
      for (int j = 0; j < numCols; j++) acc_q[j] <= '0;
    end else begin
      state_q   <= state_d;
      plane_cnt <= cnt_d;
      sat_run_q <= sat_run_d;
      err       <= err_d;
      for (int j = 0; j < numCols; j++) acc_q[j] <= acc_d[j];
      if (complete) begin
        out_valid <= 1'b1;
        sat       <= sat_run_d;
        for (int j = 0; j < numCols; j++) RESULT[j*accBits +: accBits] <= acc_d[j];
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        sat       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_qracc_psum_accumulator.sv
// Directed bench for qracc_psum_accumulator: default instance plus an 8-bit
// accumulator instance sharing the same stimulus for the saturation case.
module tb_qracc_psum_accumulator;

  localparam int NC = 8;
  localparam int CC = 15;

  logic            CLK = 1'b0;
  logic            nRST;
  logic [CC*NC-1:0] ADC_OUT;
  logic            in_valid, in_first, in_last, in_signed, out_ready;

  logic            in_ready, out_valid, err, sat;
  logic [NC*16-1:0] RESULT;
  logic [3:0]      plane_cnt;

  logic            in_ready8, out_valid8, err8, sat8;
  logic [NC*8-1:0] RESULT8;
  logic [3:0]      plane_cnt8;

  int n_pass = 0;
  int n_total = 0;

  always #5 CLK = ~CLK;

  qracc_psum_accumulator dut (
    .CLK(CLK), .nRST(nRST), .ADC_OUT(ADC_OUT), .in_valid(in_valid), .in_ready(in_ready),
    .in_first(in_first), .in_last(in_last), .in_signed(in_signed), .RESULT(RESULT),
    .out_valid(out_valid), .out_ready(out_ready), .plane_cnt(plane_cnt), .err(err), .sat(sat)
  );

  qracc_psum_accumulator #(.accBits(8)) dut8 (
    .CLK(CLK), .nRST(nRST), .ADC_OUT(ADC_OUT), .in_valid(in_valid), .in_ready(in_ready8),
    .in_first(in_first), .in_last(in_last), .in_signed(in_signed), .RESULT(RESULT8),
    .out_valid(out_valid8), .out_ready(out_ready), .plane_cnt(plane_cnt8), .err(err8), .sat(sat8)
  );

  function automatic logic [15:0] col16(int j);
    return RESULT[j*16 +: 16];
  endfunction

  function automatic logic [7:0] col8(int j);
    return RESULT8[j*8 +: 8];
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic set_in(int p0, int prest, bit f, bit l, bit s);
    logic [14:0] t;
    for (int j = 0; j < NC; j++) begin
      t = 15'((32'd1 << (j == 0 ? p0 : prest)) - 32'd1);
      ADC_OUT[j*CC +: CC] = t;
    end
    in_first  = f;
    in_last   = l;
    in_signed = s;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(int p0, int prest, bit f, bit l, bit s);
    set_in(p0, prest, f, l, s);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    nRST = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_in(8, 8, 1'b0, 1'b0, 1'b0);
    #1;
    out_ready = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(RESULT[31:0]), 32'd0);
    chk("rst_plane_cnt", 32'(plane_cnt), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_sat", 32'(sat), 32'd0);
    out_ready = 1'b1;
    #21 nRST = 1'b1;
    tick();

    // unsigned 2 planes, col0: +7 then -8 -> 6
    send(15, 8, 1, 0, 0);
    chk("t1_cnt1", 32'(plane_cnt), 32'd1);
    chk("t1_ov_mid", 32'(out_valid), 32'd0);
    send(0, 8, 0, 1, 0);
    chk("t1_ov", 32'(out_valid), 32'd1);
    chk("t1_cnt0", 32'(plane_cnt), 32'd0);
    chk("t1_col0", 32'(col16(0)), 32'h0006);
    chk("t1_col1", 32'(col16(1)), 32'h0000);
    tick();
    chk("t1_drain", 32'(out_valid), 32'd0);

    // signed 8 planes of v=+1 -> -1
    send(9, 9, 1, 0, 1);
    for (int i = 0; i < 6; i++) send(9, 9, 0, 0, 0);
    chk("t2_cnt7", 32'(plane_cnt), 32'd7);
    send(9, 9, 0, 1, 0);
    chk("t2_ov", 32'(out_valid), 32'd1);
    chk("t2_col0", 32'(col16(0)), 32'h0000FFFF);
    chk("t2_col7", 32'(col16(7)), 32'h0000FFFF);
    chk("t2_sat", 32'(sat), 32'd0);
    tick();

    // backpressure: v=3 held, v=-2 waits
    out_ready = 1'b0;
    send(11, 11, 1, 1, 0);
    chk("t3_ov", 32'(out_valid), 32'd1);
    chk("t3_col0", 32'(col16(0)), 32'h0003);
    chk("t3_in_ready", 32'(in_ready), 32'd0);
    set_in(6, 6, 1, 1, 0);
    in_valid = 1'b1;
    tick();
    chk("t3_hold", 32'(col16(0)), 32'h0003);
    chk("t3_hold_ov", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    #1;
    chk("t3_in_ready1", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("t3_reload_ov", 32'(out_valid), 32'd1);
    chk("t3_reload_col0", 32'(col16(0)), 32'h0000FFFE);
    tick();
    chk("t3_drain", 32'(out_valid), 32'd0);

    // non-first in IDLE
    send(12, 12, 0, 1, 0);
    chk("t4a_err", 32'(err), 32'd1);
    chk("t4a_ov", 32'(out_valid), 32'd0);
    tick();
    chk("t4a_err_clr", 32'(err), 32'd0);
    chk("t4a_ov2", 32'(out_valid), 32'd0);

    // restart during ACCUM: only -3*2+2 = -4
    send(13, 13, 1, 0, 0);
    chk("t4b_noerr", 32'(err), 32'd0);
    send(5, 5, 1, 0, 0);
    chk("t4b_err", 32'(err), 32'd1);
    chk("t4b_cnt", 32'(plane_cnt), 32'd1);
    send(10, 10, 0, 1, 0);
    chk("t4b_err_clr", 32'(err), 32'd0);
    chk("t4b_ov", 32'(out_valid), 32'd1);
    chk("t4b_col0", 32'(col16(0)), 32'h0000FFFC);
    tick();

    // nine planes without in_last
    send(9, 9, 1, 0, 0);
    for (int i = 0; i < 7; i++) send(9, 9, 0, 0, 0);
    chk("t4c_cnt8", 32'(plane_cnt), 32'd8);
    chk("t4c_noerr", 32'(err), 32'd0);
    send(9, 9, 0, 0, 0);
    chk("t4c_err", 32'(err), 32'd1);
    chk("t4c_cnt0", 32'(plane_cnt), 32'd0);
    chk("t4c_ov", 32'(out_valid), 32'd0);
    tick();
    chk("t4c_ov2", 32'(out_valid), 32'd0);
    chk("t4c_err_clr", 32'(err), 32'd0);

    // saturation: 8 planes of v=+7
    send(15, 15, 1, 0, 0);
    for (int i = 0; i < 6; i++) send(15, 15, 0, 0, 0);
    send(15, 15, 0, 1, 0);
    chk("t5_ov8", 32'(out_valid8), 32'd1);
    chk("t5_col0_8", 32'(col8(0)), 32'h7F);
    chk("t5_col3_8", 32'(col8(3)), 32'h7F);
    chk("t5_sat8", 32'(sat8), 32'd1);
    chk("t5_col0_16", 32'(col16(0)), 32'h06F9);
    chk("t5_sat16", 32'(sat), 32'd0);
    tick();
    chk("t5_drain_ov8", 32'(out_valid8), 32'd0);
    chk("t5_drain_sat8", 32'(sat8), 32'd0);
    send(10, 10, 1, 1, 0);
    chk("t5_clean_col0", 32'(col8(0)), 32'h02);
    chk("t5_clean_sat8", 32'(sat8), 32'd0);
    tick();

    // async reset at plane 3 of 8
    send(15, 15, 1, 0, 0);
    send(15, 15, 0, 0, 0);
    send(15, 15, 0, 0, 0);
    chk("t6_cnt3", 32'(plane_cnt), 32'd3);
    #3 nRST = 1'b0;
    #1;
    chk("t6_cnt", 32'(plane_cnt), 32'd0);
    chk("t6_result", 32'(RESULT[31:0]), 32'd0);
    chk("t6_result8", 32'(RESULT8[31:0]), 32'd0);
    chk("t6_ov", 32'(out_valid), 32'd0);
    chk("t6_err", 32'(err), 32'd0);
    chk("t6_sat", 32'(sat), 32'd0);
    #2 nRST = 1'b1;
    tick();
    send(11, 11, 1, 0, 0);
    send(3, 3, 0, 1, 0);
    chk("t6_fresh_ov", 32'(out_valid), 32'd1);
    chk("t6_fresh_col0", 32'(col16(0)), 32'h0001);
    chk("t6_fresh_col5", 32'(col16(5)), 32'h0001);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
